// File: rtl/rr_stream_arbiter_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package rr_stream_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Minimum 1 so a 1-entry range still gets a real bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_stream_arbiter_pick.sv
// Rotating priority encoder: first set request strictly after base, wrapping.
module rr_pick
    import rr_stream_arbiter_pkg::*;
#(
    parameter int N = 4,
    localparam int W = clog2(N)
)(
    input  logic [N-1:0] req,
    input  logic [W-1:0] base,
    output logic         found,
    output logic [W-1:0] index
);

    always_comb begin
        int j;
        logic [W-1:0] jw;
        found = 1'b0;
        index = '0;
        j     = 0;
        jw    = '0;
        // i = N brings the search back round to base itself last.
        for (int i = 1; i <= N; i++) begin
            j  = (int'(base) + i) % N;
            jw = W'(j);
            if (!found && req[jw]) begin
                found = 1'b1;
                index = jw;
            end
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin merge of FWFT source FIFOs into one registered, back-pressured sink.
module rr_stream_arbiter
    import rr_stream_arbiter_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int CNT_WIDTH  = 16,
    localparam int IDW = clog2(CHANNELS)
)(
    input  logic                           BUS_CLK,
    input  logic                           BUS_RST,
    input  logic [CHANNELS-1:0]            CH_ENABLE,
    input  logic [CHANNELS-1:0]            WRITE_REQ,
    input  logic [CHANNELS-1:0]            HOLD_REQ,
    input  logic [CHANNELS*DATA_WIDTH-1:0] DATA_IN,
    output logic [CHANNELS-1:0]            READ_GRANT,
    input  logic                           READY_IN,
    output logic                           WRITE_OUT,
    output logic [DATA_WIDTH-1:0]          DATA_OUT,
    output logic [IDW-1:0]                 CH_ID_OUT,
    input  logic                           CNT_CLEAR,
    output logic [CNT_WIDTH-1:0]           WORD_CNT
);

    localparam int BW = clog2(MAX_BURST + 1);

    arb_state_t      state, state_nxt;
    logic [IDW-1:0]  g, g_nxt;
    logic [IDW-1:0]  ptr, ptr_nxt;
    logic [BW-1:0]   burst, burst_nxt;
    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic            pop;
    logic [DATA_WIDTH-1:0] data_sel;

    rr_pick #(.N(CHANNELS)) u_pick (
        .req   (CH_ENABLE & WRITE_REQ),
        .base  (ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    assign data_sel = DATA_IN[g*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_nxt  = state;
        g_nxt      = g;
        ptr_nxt    = ptr;
        burst_nxt  = burst;
        pop        = 1'b0;
        READ_GRANT = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    g_nxt     = pick_idx;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                pop           = WRITE_REQ[g] & CH_ENABLE[g] & (!WRITE_OUT | READY_IN);
                READ_GRANT[g] = pop;
                // Saturates so a long held packet cannot wrap the count.
                if (pop && burst != BW'(MAX_BURST))
                    burst_nxt = burst + 1'b1;
                if (!CH_ENABLE[g] ||
                    (!HOLD_REQ[g] && (!WRITE_REQ[g] || (pop && burst_nxt == BW'(MAX_BURST))))) begin
                    state_nxt = IDLE;
                    ptr_nxt   = g;
                    burst_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state <= IDLE;
            g     <= '0;
            ptr   <= IDW'(CHANNELS - 1);
            burst <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            ptr   <= ptr_nxt;
            burst <= burst_nxt;
        end
    end

    // Output register: a pop refills it, an accepted word with no refill empties it.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            WRITE_OUT <= 1'b0;
            DATA_OUT  <= '0;
            CH_ID_OUT <= '0;
        end else if (pop) begin
            WRITE_OUT <= 1'b1;
            DATA_OUT  <= data_sel;
            CH_ID_OUT <= g;
        end else if (READY_IN) begin
            WRITE_OUT <= 1'b0;
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST)
            WORD_CNT <= '0;
        else if (CNT_CLEAR)
            WORD_CNT <= '0;
        else if (WRITE_OUT && READY_IN && WORD_CNT != '1)
            WORD_CNT <= WORD_CNT + 1'b1;
    end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Scoreboard bench: FIFO source models feed the arbiter, a monitor checks every accepted word.
module tb_rr_stream_arbiter;

    localparam int CH = 4;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int CW = 4;

    logic                BUS_CLK   = 1'b0;
    logic                BUS_RST   = 1'b1;
    logic [CH-1:0]       CH_ENABLE = '0;
    logic [CH-1:0]       WRITE_REQ = '0;
    logic [CH-1:0]       HOLD_REQ  = '0;
    logic [CH*DW-1:0]    DATA_IN   = '0;
    logic [CH-1:0]       READ_GRANT;
    logic                READY_IN  = 1'b0;
    logic                WRITE_OUT;
    logic [DW-1:0]       DATA_OUT;
    logic [1:0]          CH_ID_OUT;
    logic                CNT_CLEAR = 1'b0;
    logic [CW-1:0]       WORD_CNT;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] fifo [CH][$];
    int            xfer_cyc[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    logic [CH-1:0] last_gr = '0;

    rr_stream_arbiter #(
        .CHANNELS   (CH),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB),
        .CNT_WIDTH  (CW)
    ) dut (
        .BUS_CLK    (BUS_CLK),
        .BUS_RST    (BUS_RST),
        .CH_ENABLE  (CH_ENABLE),
        .WRITE_REQ  (WRITE_REQ),
        .HOLD_REQ   (HOLD_REQ),
        .DATA_IN    (DATA_IN),
        .READ_GRANT (READ_GRANT),
        .READY_IN   (READY_IN),
        .WRITE_OUT  (WRITE_OUT),
        .DATA_OUT   (DATA_OUT),
        .CH_ID_OUT  (CH_ID_OUT),
        .CNT_CLEAR  (CNT_CLEAR),
        .WORD_CNT   (WORD_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    function automatic logic [DW-1:0] wd(input int t, input int c, input int s);
        return {8'(t), 8'(c), 16'(s)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input int c, input logic [DW-1:0] d);
        sb.push_back('{id: 2'(c), data: d});
    endtask

    // One cycle, entered and left at a falling edge; the source FIFOs pop on granted edges.
    task automatic tick();
        for (int c = 0; c < CH; c++) begin
            WRITE_REQ[c]      = fifo[c].size() != 0;
            DATA_IN[c*DW +: DW] = (fifo[c].size() != 0) ? fifo[c][0] : '0;
        end
        #1 last_gr = READ_GRANT;
        @(posedge BUS_CLK);
        for (int c = 0; c < CH; c++) begin
            if (last_gr[c]) begin
                check("pop_nonempty", 64'(fifo[c].size() != 0), 64'd1);
                if (fifo[c].size() != 0) void'(fifo[c].pop_front());
            end
        end
        @(negedge BUS_CLK);
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check({name, "_drained"}, 64'(sb.size()), 64'd0);
        repeat (3) tick();
    endtask

    // Monitor: compare each accepted word against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge BUS_CLK);
            #3;
            cyc++;
            if (!BUS_RST && WRITE_OUT && READY_IN) begin
                xfer_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got ch%0d data %h, expected no word", CH_ID_OUT, DATA_OUT);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_id", 64'(CH_ID_OUT), 64'(e.id));
                    check("out_data", 64'(DATA_OUT), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with requests present so a zero grant is meaningful.
        CH_ENABLE = '1;
        WRITE_REQ = '1;
        repeat (2) @(negedge BUS_CLK);
        check("rst_write_out", 64'(WRITE_OUT), 64'd0);
        check("rst_data_out", 64'(DATA_OUT), 64'd0);
        check("rst_ch_id", 64'(CH_ID_OUT), 64'd0);
        check("rst_word_cnt", 64'(WORD_CNT), 64'd0);
        check("rst_grant", 64'(READ_GRANT), 64'd0);
        WRITE_REQ = '0;
        BUS_RST   = 1'b0;
        READY_IN  = 1'b1;

        // Reset mid-burst: w0 delivered, w1 sitting in the output register is discarded.
        for (int s = 0; s < 6; s++) fifo[0].push_back(wd(1, 0, s));
        expect_word(0, wd(1, 0, 0));
        repeat (3) tick();
        check("midrst_pre_data", 64'(DATA_OUT), 64'(wd(1, 0, 1)));
        check("midrst_sb", 64'(sb.size()), 64'd0);
        #2 BUS_RST = 1'b1;
        #1;
        check("midrst_write_out", 64'(WRITE_OUT), 64'd0);
        check("midrst_data_out", 64'(DATA_OUT), 64'd0);
        check("midrst_ch_id", 64'(CH_ID_OUT), 64'd0);
        check("midrst_word_cnt", 64'(WORD_CNT), 64'd0);
        check("midrst_grant", 64'(READ_GRANT), 64'd0);
        repeat (2) @(negedge BUS_CLK);
        fifo[0].delete();
        BUS_RST = 1'b0;

        // Fairness: bursts of 4 in channel order starting at 0, one idle cycle between.
        for (int c = 0; c < CH; c++)
            for (int s = 0; s < 8; s++) fifo[c].push_back(wd(2, c, s));
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < CH; c++)
                for (int s = 4 * r; s < 4 * r + 4; s++) expect_word(c, wd(2, c, s));
        xfer_cyc.delete();
        drain("fair", 100);
        check("fair_xfers", 64'(xfer_cyc.size()), 64'd32);
        if (xfer_cyc.size() >= 16)
            check("fair_span16", 64'(xfer_cyc[15] - xfer_cyc[0]), 64'd18);

        // Backpressure: five stalled cycles with w1 held in the output register.
        for (int s = 0; s < 6; s++) begin
            fifo[1].push_back(wd(3, 1, s));
            expect_word(1, wd(3, 1, s));
        end
        repeat (3) tick();
        READY_IN = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_grant", 64'(last_gr), 64'd0);
            check("bp_valid", 64'(WRITE_OUT), 64'd1);
            check("bp_data", 64'(DATA_OUT), 64'(wd(3, 1, 1)));
        end
        READY_IN = 1'b1;
        drain("bp", 50);

        // Mask 1010: last release was channel 1, so channel 3 leads.
        CH_ENABLE = 4'b1010;
        for (int c = 0; c < CH; c++)
            for (int s = 0; s < 8; s++) fifo[c].push_back(wd(4, c, s));
        for (int r = 0; r < 2; r++) begin
            for (int s = 4 * r; s < 4 * r + 4; s++) expect_word(3, wd(4, 3, s));
            for (int s = 4 * r; s < 4 * r + 4; s++) expect_word(1, wd(4, 1, s));
        end
        drain("mask", 100);
        check("mask_ch0_left", 64'(fifo[0].size()), 64'd8);
        check("mask_ch2_left", 64'(fifo[2].size()), 64'd8);
        fifo[0].delete();
        fifo[2].delete();

        // Disabling channel 3 mid-grant stops its pops in that same cycle.
        for (int s = 0; s < 4; s++) fifo[3].push_back(wd(5, 3, s));
        expect_word(3, wd(5, 3, 0));
        expect_word(3, wd(5, 3, 1));
        repeat (3) tick();
        CH_ENABLE = 4'b0010;
        tick();
        check("mask_off_grant", 64'(last_gr), 64'd0);
        drain("mask_off", 20);
        check("mask_off_left", 64'(fifo[3].size()), 64'd2);
        fifo[3].delete();
        CH_ENABLE = '1;

        // Hold: channel 2 keeps the grant through gaps and past MAX_BURST.
        HOLD_REQ = 4'b0100;
        for (int w = 0; w < 20; w++) begin
            int n;
            fifo[2].push_back(wd(6, 2, w));
            expect_word(2, wd(6, 2, w));
            n = 0;
            while (fifo[2].size() != 0 && n < 10) begin
                tick();
                n++;
            end
            repeat (3) tick();
            if (w == 0)
                for (int c = 0; c < CH; c++)
                    if (c != 2)
                        for (int s = 0; s < 2; s++) fifo[c].push_back(wd(6, c, s));
        end
        check("hold_sb", 64'(sb.size()), 64'd0);
        HOLD_REQ = '0;
        for (int s = 0; s < 2; s++) expect_word(3, wd(6, 3, s));
        for (int s = 0; s < 2; s++) expect_word(0, wd(6, 0, s));
        for (int s = 0; s < 2; s++) expect_word(1, wd(6, 1, s));
        drain("hold", 50);

        // Counter: clear, saturate at 15, clear beating a coincident transfer.
        CNT_CLEAR = 1'b1;
        tick();
        CNT_CLEAR = 1'b0;
        check("cnt_clear", 64'(WORD_CNT), 64'd0);
        for (int s = 0; s < 20; s++) begin
            fifo[0].push_back(wd(7, 0, s));
            expect_word(0, wd(7, 0, s));
        end
        drain("cnt20", 100);
        check("cnt_sat", 64'(WORD_CNT), 64'd15);
        fifo[0].push_back(wd(8, 0, 0));
        expect_word(0, wd(8, 0, 0));
        repeat (2) tick();
        check("cnt_pre_valid", 64'(WRITE_OUT), 64'd1);
        CNT_CLEAR = 1'b1;
        tick();
        CNT_CLEAR = 1'b0;
        check("cnt_clear_xfer", 64'(WORD_CNT), 64'd0);
        fifo[0].push_back(wd(8, 0, 1));
        expect_word(0, wd(8, 0, 1));
        drain("cnt1", 20);
        check("cnt_one", 64'(WORD_CNT), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
